// File: rtl/cio_bridge_pkg.sv
// Shared types, defaults and BCD/byte conversion helpers for the CPU I/O bridge.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
package cio_bridge_pkg;

  localparam int DATA_DEKATRON_NUM = 3;  // BCD digits per CPU data word
  localparam int DEKATRON_WIDTH    = 4;  // bits per BCD digit
  localparam int CIO_FIFO_DEPTH    = 4;  // default entries per TX/RX FIFO

  typedef enum logic [1:0] {
    IDLE,
    OUT_ACK,
    IN_ACK,
    RELEASE
  } cio_state_t;

  // Digits are weighted as raw nibbles (no BCD validity check); the result
  // wraps modulo 256. The largest raw sum, 15*111 = 1665, fits in 11 bits.
  function automatic logic [7:0] to_byte(input logic [3:0] d2,
                                         input logic [3:0] d1,
                                         input logic [3:0] d0);
    return 8'(11'(d2) * 11'd100 + 11'(d1) * 11'd10 + 11'(d0));
  endfunction

  // Byte 0..255 to three BCD digits {hundreds, tens, ones}.
  function automatic logic [11:0] to_bcd(input logic [7:0] b);
    return {4'(b / 8'd100), 4'((b / 8'd10) % 8'd10), 4'(b % 8'd10)};
  endfunction

endpackage

// File: rtl/cio_fifo.sv
// Synchronous FIFO for the bridge byte streams; push/pop ignored when full/empty.
// Latency: one cycle from push to head visible; head is the current oldest entry.
// Backpressure: full/empty come from the registered count, so a same-cycle pop
// never frees space for a push into a full FIFO.
// Ports: clk, rst (sync active-high), push/push_data, pop, head, full, empty.
module cio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through valid counts.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cio_bridge.sv
// Bridges CPU COUT/CIN level requests to host valid/ready byte streams via TX/RX FIFOs.
// Latency: request seen in IDLE at edge N gives a one-cycle CioAcq during cycle N+1.
// Backpressure: a request is held off (no ack, no push/pop) while its FIFO is full/empty.
// Ports: Clk, Rst (sync active-high); CPU side Cout, CinReq, Data -> CioAcq, DataCin;
// host side TxData/TxValid/TxReady out, RxData/RxValid in with RxReady.
// Option: define CIO_ECHO_EN to echo every byte consumed by CIN onto the TX stream.
module cio_bridge
  import cio_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH = CIO_FIFO_DEPTH,
  parameter int DIGITS     = DATA_DEKATRON_NUM
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic                             Cout,
  input  logic                             CinReq,
  input  logic [DIGITS*DEKATRON_WIDTH-1:0] Data,
  output logic                             CioAcq,
  output logic [DIGITS*DEKATRON_WIDTH-1:0] DataCin,
  output logic [7:0]                       TxData,
  output logic                             TxValid,
  input  logic                             TxReady,
  input  logic [7:0]                       RxData,
  input  logic                             RxValid,
  output logic                             RxReady
);

  localparam int DW = DIGITS * DEKATRON_WIDTH;

  cio_state_t    state_q, state_d;
  logic          cio_acq_q, cio_acq_d;
  logic [DW-1:0] data_cin_q, data_cin_d;

  logic          tx_push, tx_full, tx_empty;
  logic [7:0]    tx_push_data;
  logic          rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_head;
  logic          cin_go;
  logic [3:0]    dig [3];

  // Missing upper digits (DIGITS < 3) convert as zero.
  for (genvar i = 0; i < 3; i++) begin : g_dig
    if (i < DIGITS) begin : g_have
      assign dig[i] = Data[i*DEKATRON_WIDTH +: DEKATRON_WIDTH];
    end else begin : g_none
      assign dig[i] = '0;
    end
  end

`ifdef CIO_ECHO_EN
  // The echoed byte needs TX room, otherwise it would be lost.
  assign cin_go = CinReq & ~rx_empty & ~tx_full;
`else
  assign cin_go = CinReq & ~rx_empty;
`endif

  always_comb begin
    state_d      = state_q;
    cio_acq_d    = 1'b0;
    data_cin_d   = data_cin_q;
    tx_push      = 1'b0;
    tx_push_data = to_byte(dig[2], dig[1], dig[0]);
    rx_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // Cout wins outright: a blocked Cout also blocks CIN service.
        if (Cout) begin
          if (!tx_full) begin
            tx_push   = 1'b1;
            cio_acq_d = 1'b1;
            state_d   = OUT_ACK;
          end
        end else if (cin_go) begin
          rx_pop     = 1'b1;
          data_cin_d = DW'(to_bcd(rx_head));
          cio_acq_d  = 1'b1;
          state_d    = IN_ACK;
`ifdef CIO_ECHO_EN
          tx_push      = 1'b1;
          tx_push_data = rx_head;
`endif
        end
      end
      OUT_ACK, IN_ACK: state_d = RELEASE;
      // Wait for both request levels to drop so one request gets one ack.
      RELEASE: if (!Cout && !CinReq) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cio_acq_q  <= 1'b0;
      data_cin_q <= '0;
    end else begin
      state_q    <= state_d;
      cio_acq_q  <= cio_acq_d;
      data_cin_q <= data_cin_d;
    end
  end

  assign CioAcq  = cio_acq_q;
  assign DataCin = data_cin_q;
  assign TxValid = ~tx_empty;
  assign RxReady = ~rx_full;

  cio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (TxValid & TxReady),
    .head      (TxData),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  cio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (RxValid & RxReady),
    .push_data (RxData),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty)
  );

endmodule

// File: tb/tb_cio_bridge.sv
// Directed testbench for cio_bridge: CPU handshakes, FIFO backpressure, reset abort.
// Latency: n/a (testbench).
// Backpressure: driven directly via TxReady/RxValid.
module tb_cio_bridge;

  logic        Clk = 1'b0;
  logic        Rst, Cout, CinReq, TxReady, RxValid;
  logic [11:0] Data;
  logic [7:0]  RxData;
  logic        CioAcq, TxValid, RxReady;
  logic [11:0] DataCin;
  logic [7:0]  TxData;

  int n_tests = 0;
  int n_fail  = 0;
  int acq_cnt = 0;
  int tx_beats = 0;
  int a0, b0;

  cio_bridge #(.FIFO_DEPTH(4), .DIGITS(3)) dut (
    .Clk(Clk), .Rst(Rst), .Cout(Cout), .CinReq(CinReq), .Data(Data),
    .CioAcq(CioAcq), .DataCin(DataCin), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (CioAcq) acq_cnt++;
    if (TxValid && TxReady) tx_beats++;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    RxData = b; RxValid = 1'b1;
    step();
    RxValid = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(); step();
    n_tests++; if (CioAcq !== 1'b0) begin n_fail++; $display("FAIL reset_acq got %b exp 0", CioAcq); end
    n_tests++; if (DataCin !== 12'h000) begin n_fail++; $display("FAIL reset_datacin got %h exp 000", DataCin); end
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL reset_txvalid got %b exp 0", TxValid); end
    n_tests++; if (RxReady !== 1'b1) begin n_fail++; $display("FAIL reset_rxready got %b exp 1", RxReady); end
    Rst = 1'b0;
    step();
  endtask

  task automatic test_out();
    TxReady = 1'b1; Data = 12'h065; Cout = 1'b1;
    a0 = acq_cnt; b0 = tx_beats;
    step();
    n_tests++; if (CioAcq !== 1'b1) begin n_fail++; $display("FAIL out_acq got %b exp 1", CioAcq); end
    n_tests++; if (TxValid !== 1'b1) begin n_fail++; $display("FAIL out_txvalid got %b exp 1", TxValid); end
    n_tests++; if (TxData !== 8'h41) begin n_fail++; $display("FAIL out_txdata got %h exp 41", TxData); end
    step();
    n_tests++; if (CioAcq !== 1'b0) begin n_fail++; $display("FAIL out_acq_drop got %b exp 0", CioAcq); end
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL out_tx_drained got %b exp 0", TxValid); end
    step();
    Cout = 1'b0;
    step(); step();
    n_tests++; if (acq_cnt - a0 !== 1) begin n_fail++; $display("FAIL out_acq_pulses got %0d exp 1", acq_cnt - a0); end
    n_tests++; if (tx_beats - b0 !== 1) begin n_fail++; $display("FAIL out_tx_beats got %0d exp 1", tx_beats - b0); end
    TxReady = 1'b0;
  endtask

  task automatic test_cin();
    TxReady = 1'b0;
    rx_push(8'hFF);
    CinReq = 1'b1; a0 = acq_cnt;
    step();
    n_tests++; if (CioAcq !== 1'b1) begin n_fail++; $display("FAIL cin_acq got %b exp 1", CioAcq); end
    n_tests++; if (DataCin !== 12'h255) begin n_fail++; $display("FAIL cin_datacin got %h exp 255", DataCin); end
`ifdef CIO_ECHO_EN
    n_tests++; if (TxValid !== 1'b1 || TxData !== 8'hFF) begin n_fail++; $display("FAIL cin_echo got v=%b d=%h exp v=1 d=ff", TxValid, TxData); end
`else
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL cin_no_echo got %b exp 0", TxValid); end
`endif
    step(); step(); step();
    n_tests++; if (acq_cnt - a0 !== 1) begin n_fail++; $display("FAIL cin_single_ack got %0d exp 1", acq_cnt - a0); end
    CinReq = 1'b0;
    step(); step();
    // RX is empty now: a new CIN must not be acknowledged
    CinReq = 1'b1; a0 = acq_cnt;
    step(); step(); step();
    n_tests++; if (acq_cnt !== a0 || CioAcq !== 1'b0) begin n_fail++; $display("FAIL cin_rx_empty got %0d acks exp 0", acq_cnt - a0); end
    n_tests++; if (DataCin !== 12'h255) begin n_fail++; $display("FAIL cin_hold got %h exp 255", DataCin); end
    CinReq = 1'b0;
    TxReady = 1'b1; step(); step(); TxReady = 1'b0;
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL cin_tx_clear got %b exp 0", TxValid); end
  endtask

  task automatic test_backpressure();
    TxReady = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      Data = 12'(k); Cout = 1'b1;
      step();
      n_tests++; if (CioAcq !== 1'b1) begin n_fail++; $display("FAIL fill_acq_%0d got %b exp 1", k, CioAcq); end
      Cout = 1'b0;
      step(); step();
    end
    n_tests++; if (TxValid !== 1'b1 || TxData !== 8'h01) begin n_fail++; $display("FAIL fill_head got v=%b d=%h exp v=1 d=01", TxValid, TxData); end
    Data = 12'h005; Cout = 1'b1; a0 = acq_cnt;
    step(); step(); step();
    n_tests++; if (CioAcq !== 1'b0 || acq_cnt !== a0) begin n_fail++; $display("FAIL full_no_ack got %0d acks exp 0", acq_cnt - a0); end
    TxReady = 1'b1;
    step();
    TxReady = 1'b0;
    n_tests++; if (CioAcq !== 1'b0 || TxData !== 8'h02) begin n_fail++; $display("FAIL full_pop got acq=%b d=%h exp acq=0 d=02", CioAcq, TxData); end
    step();
    n_tests++; if (CioAcq !== 1'b1) begin n_fail++; $display("FAIL full_late_ack got %b exp 1", CioAcq); end
    Cout = 1'b0;
    step(); step();
    TxReady = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      n_tests++; if (TxValid !== 1'b1 || TxData !== 8'(k)) begin n_fail++; $display("FAIL drain_%0d got v=%b d=%h exp v=1 d=%h", k, TxValid, TxData, 8'(k)); end
      step();
    end
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", TxValid); end
    TxReady = 1'b0;
  endtask

  task automatic test_priority();
    TxReady = 1'b0;
    rx_push(8'h07);
    Data = 12'h300; Cout = 1'b1; CinReq = 1'b1;
    step();
    n_tests++; if (CioAcq !== 1'b1 || TxData !== 8'h2C) begin n_fail++; $display("FAIL prio_out got acq=%b d=%h exp acq=1 d=2c", CioAcq, TxData); end
    n_tests++; if (DataCin !== 12'h255) begin n_fail++; $display("FAIL prio_cin_untouched got %h exp 255", DataCin); end
    Cout = 1'b0;
    step(); step();
    n_tests++; if (CioAcq !== 1'b0 || DataCin !== 12'h255) begin n_fail++; $display("FAIL prio_release got acq=%b dc=%h exp acq=0 dc=255", CioAcq, DataCin); end
    CinReq = 1'b0;
    step();
    CinReq = 1'b1;
    step();
    n_tests++; if (CioAcq !== 1'b1 || DataCin !== 12'h007) begin n_fail++; $display("FAIL prio_cin_after got acq=%b dc=%h exp acq=1 dc=007", CioAcq, DataCin); end
    CinReq = 1'b0;
    step(); step();
    TxReady = 1'b1; step(); step(); TxReady = 1'b0;
  endtask

  task automatic test_rx_full();
    TxReady = 1'b1;
    for (int k = 1; k <= 4; k++) rx_push(8'(k));
    n_tests++; if (RxReady !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready got %b exp 0", RxReady); end
    rx_push(8'h99);
    for (int k = 1; k <= 4; k++) begin
      CinReq = 1'b1;
      step();
      n_tests++; if (CioAcq !== 1'b1 || DataCin !== 12'(k)) begin n_fail++; $display("FAIL rx_order_%0d got acq=%b dc=%h exp acq=1 dc=%h", k, CioAcq, DataCin, 12'(k)); end
      CinReq = 1'b0;
      step(); step();
    end
    CinReq = 1'b1; a0 = acq_cnt;
    step(); step();
    n_tests++; if (acq_cnt !== a0 || CioAcq !== 1'b0) begin n_fail++; $display("FAIL rx_overflow_dropped got %0d acks exp 0", acq_cnt - a0); end
    CinReq = 1'b0;
    step();
    TxReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    TxReady = 1'b0; Data = 12'h065; Cout = 1'b1;
    step();
    n_tests++; if (CioAcq !== 1'b1 || TxValid !== 1'b1) begin n_fail++; $display("FAIL mid_pre got acq=%b v=%b exp 1 1", CioAcq, TxValid); end
    Rst = 1'b1;
    step();
    n_tests++; if (CioAcq !== 1'b0 || TxValid !== 1'b0 || DataCin !== 12'h000) begin n_fail++; $display("FAIL mid_reset got acq=%b v=%b dc=%h exp 0 0 000", CioAcq, TxValid, DataCin); end
    Rst = 1'b0;
    step();
    n_tests++; if (CioAcq !== 1'b1 || TxValid !== 1'b1 || TxData !== 8'h41) begin n_fail++; $display("FAIL mid_reservice got acq=%b v=%b d=%h exp 1 1 41", CioAcq, TxValid, TxData); end
    step();
    n_tests++; if (CioAcq !== 1'b0) begin n_fail++; $display("FAIL mid_one_ack got %b exp 0", CioAcq); end
    Cout = 1'b0;
    step(); step();
    TxReady = 1'b1; step(); TxReady = 1'b0;
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL mid_single_entry got %b exp 0", TxValid); end
  endtask

  task automatic test_echo();
    TxReady = 1'b0;
    rx_push(8'h30);
    CinReq = 1'b1;
    step();
    n_tests++; if (CioAcq !== 1'b1 || DataCin !== 12'h048) begin n_fail++; $display("FAIL echo_cin got acq=%b dc=%h exp 1 048", CioAcq, DataCin); end
`ifdef CIO_ECHO_EN
    n_tests++; if (TxValid !== 1'b1 || TxData !== 8'h30) begin n_fail++; $display("FAIL echo_tx got v=%b d=%h exp 1 30", TxValid, TxData); end
`else
    n_tests++; if (TxValid !== 1'b0) begin n_fail++; $display("FAIL echo_tx_idle got %b exp 0", TxValid); end
`endif
    CinReq = 1'b0;
    step(); step();
    TxReady = 1'b1; step(); TxReady = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Cout = 1'b0; CinReq = 1'b0; TxReady = 1'b0;
    RxValid = 1'b0; RxData = 8'h00; Data = 12'h000;
    test_reset();
    test_out();
    test_cin();
    test_backpressure();
    test_priority();
    test_rx_full();
    test_reset_mid();
    test_echo();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
